rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter directly upstream of the 16-to-4 case encoder.
- Samples up to N request lines and issues one one-hot grant vector with a valid flag.
- grant_out drives the encoder's 16-bit one-hot input; grant_valid drives the encoder's enable.
- Fairness uses a rotating priority pointer, advanced only when a grant is accepted through a valid/ready handshake.

Parameters:
- N, 16, number of requesters and width of req_in/grant_out; legal range 2..16.
- PW, $clog2(N), width of the internal priority pointer. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new grants to be issued; an outstanding grant is never withdrawn.
- req_in  input  N  request vector; bit i high = requester i wants service; level-sensitive.
- grant_ready  input  1  downstream accepts the current grant this cycle.
- grant_out  output  N  registered one-hot grant; all-zero when grant_valid=0.
- grant_valid  output  1  registered; high while grant_out holds a valid grant.

Behaviour:
- Reset (synchronous, sampled at rising clk with reset=1):
  - grant_out=0, grant_valid=0, ptr=0, state=IDLE.
  - Reset overrides all other inputs, including mid-grant; no handshake completes that cycle.
- Selection function: pick the lowest index i ≥ ptr with req_in[i]=1; if none, pick the lowest index i < ptr with req_in[i]=1 (wrap-around). Result is exactly one-hot or zero.
- IDLE state:
  - If enable=1 and req_in≠0: register the selected one-hot into grant_out, set grant_valid=1, go to GRANT.
  - Latency is one cycle from request sample to grant_valid.
  - Otherwise remain in IDLE with outputs at zero.
- GRANT state:
  - grant_out and grant_valid hold stable while grant_ready=0, regardless of changes on req_in or enable. A requester dropping its req does not cancel its grant.
  - On grant_valid=1 and grant_ready=1 (accept), for granted index g:
    - ptr <= (g+1) mod N; 15→0 wrap is required for N=16.
    - Same cycle, if enable=1 and req_in≠0: select again using ptr'=(g+1) mod N and register the new grant. Stay in GRANT with grant_valid=1, giving back-to-back grants with no bubble.
    - Otherwise grant_out<=0, grant_valid<=0, go to IDLE.
- A req_in bit that is still high at accept time for the just-granted requester is eligible again, but at lowest priority.
- ptr changes only on accept, never on issue.
- Invariant: grant_out is one-hot when grant_valid=1 and zero when grant_valid=0. Must be checked by assertion.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then req_in=16'h0002 with enable=1 and grant_ready=1 held high: grant_out=16'h0002 and grant_valid=1 one cycle later. After the accept, ptr=2; with req held, the next grant is again 16'h0002.
- req_in=16'h8001, ptr=0, grant_ready=1 continuous: grants alternate 16'h0001, 16'h8000, 16'h0001 on consecutive cycles with no gap. Confirms the 15→0 wrap.
- Grant 16'h0010 issued, grant_ready=0 for 5 cycles while req_in changes to 16'h0100: grant_out stays 16'h0010 with valid high. On grant_ready=1 it is accepted, and 16'h0100 follows next.
- enable=0 with req_in=16'hFFFF from IDLE: no grant for 10 cycles. Raising enable gives grant 16'h0001 after one cycle. Dropping enable during an outstanding grant: that grant completes on accept, then valid falls and the FSM returns to IDLE.
- Assert reset while grant_valid=1 and grant_ready=1 in the same cycle: next cycle grant_out=0, grant_valid=0, ptr=0. The first post-reset grant for req_in=16'h0006 is 16'h0002.
- Random req_in/grant_ready/enable for 10k cycles: the one-hot invariant always holds. No requester with req continuously high waits more than N-1 accepted grants.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin arbiter that feeds a one-hot encoder.
//
// Samples up to N request lines and issues a registered one-hot grant with a
// valid flag. A rotating priority pointer advances only when a grant is
// accepted (grant_valid & grant_ready). On accept, a new grant can be issued
// in the same cycle, so back-to-back grants have no bubble.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   enable       permits new grants; an outstanding grant is never withdrawn
//   req_in       N-bit level-sensitive request vector
//   grant_ready  downstream accepts the current grant this cycle
//   grant_out    registered one-hot grant, zero when grant_valid=0
//   grant_valid  registered valid flag for grant_out
module rr_grant_arbiter #(
    parameter int unsigned N  = 16,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req_in,
    input  logic         grant_ready,
    output logic [N-1:0] grant_out,
    output logic         grant_valid
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q;
    logic [N-1:0]    grant_q;
    logic            valid_q;
    logic [PW-1:0]   ptr_q;

    logic [PW-1:0]   gidx;
    logic [PW-1:0]   ptr_next;
    logic            accept;
    logic [PW-1:0]   sel_base;
    logic [N-1:0]    sel;

    // First requester at or after base, wrapping around to index 0.
    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [PW-1:0] base);
        logic [N-1:0] oh;
        logic         found;
        int unsigned  idx;
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (int'(base) + k) % N;
            if (!found && req[PW'(idx)]) begin
                oh[PW'(idx)] = 1'b1;
                found        = 1'b1;
            end
        end
        return oh;
    endfunction

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
        // Explicit wrap so non-power-of-two N also rotates correctly.
        ptr_next = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        accept   = valid_q & grant_ready;
        // On accept the re-selection already uses the advanced pointer, which
        // puts the just-served requester at lowest priority.
        sel_base = accept ? ptr_next : ptr_q;
        sel      = pick(req_in, sel_base);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable && (req_in != '0)) begin
                        grant_q <= sel;
                        valid_q <= 1'b1;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    // Hold the grant until it is accepted.
                    if (grant_ready) begin
                        ptr_q <= ptr_next;
                        if (enable && (req_in != '0)) begin
                            grant_q <= sel;
                            valid_q <= 1'b1;
                        end else begin
                            grant_q <= '0;
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_out   = grant_q;
    assign grant_valid = valid_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        grant_valid ? $onehot(grant_out) : (grant_out == '0));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic         grant_ready = 1'b0;
    logic [N-1:0] grant_out;
    logic         grant_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: grant held as an integer index, pointer as an integer.
    bit m_valid = 1'b0;
    int m_g     = 0;
    int m_ptr   = 0;

    rr_grant_arbiter #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_in     (req),
        .grant_ready(grant_ready),
        .grant_out  (grant_out),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] v;
        v = '0;
        if (m_valid) v[m_g] = 1'b1;
        return v;
    endfunction

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic tick();
        if (reset) begin
            m_valid = 1'b0;
            m_g     = 0;
            m_ptr   = 0;
        end else if (!m_valid) begin
            if (enable && req != '0) begin
                m_g     = first_from(req, m_ptr);
                m_valid = 1'b1;
            end
        end else if (grant_ready) begin
            m_ptr = (m_g + 1) % N;
            if (enable && req != '0) m_g = first_from(req, m_ptr);
            else m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; req = '0; grant_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (grant_out !== 16'h0000 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got grant=%h valid=%b, want 0000/0", grant_out, grant_valid);
        end
        total++;
        if (dut.ptr_q !== 4'd0) begin
            bad++;
            $display("FAIL reset_ptr: got %0d, want 0", dut.ptr_q);
        end
        req = 16'h0002; enable = 1'b1; grant_ready = 1'b1;
        tick();
        total++;
        if (grant_out !== 16'h0002 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: got %h/%b, want 0002/1", grant_out, grant_valid);
        end
        tick();
        total++;
        if (grant_out !== 16'h0002 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL regrant_same: got %h/%b, want 0002/1", grant_out, grant_valid);
        end
        total++;
        if (dut.ptr_q !== 4'd2) begin
            bad++;
            $display("FAIL ptr_after_accept: got %0d, want 2", dut.ptr_q);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] exp_seq [4];
        exp_seq[0] = 16'h0001; exp_seq[1] = 16'h8000;
        exp_seq[2] = 16'h0001; exp_seq[3] = 16'h8000;
        do_reset();
        req = 16'h8001; enable = 1'b1; grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (grant_out !== exp_seq[i] || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL wrap_%0d: got %h/%b, want %h/1", i, grant_out, grant_valid,
                         exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 16'h0010; enable = 1'b1; grant_ready = 1'b0;
        tick();
        req = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (grant_out !== 16'h0010 || grant_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d: got %h/%b, want 0010/1", i, grant_out, grant_valid);
            end
        end
        grant_ready = 1'b1;
        tick();
        total++;
        if (grant_out !== 16'h0100 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_next: got %h/%b, want 0100/1", grant_out, grant_valid);
        end
    endtask

    task automatic test_enable();
        do_reset();
        req = 16'hFFFF; enable = 1'b0; grant_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (grant_valid !== 1'b0 || grant_out !== 16'h0000) begin
                bad++;
                $display("FAIL disabled_%0d: got %h/%b, want 0000/0", i, grant_out, grant_valid);
            end
        end
        enable = 1'b1;
        tick();
        total++;
        if (grant_out !== 16'h0001 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL enable_grant: got %h/%b, want 0001/1", grant_out, grant_valid);
        end
        enable = 1'b0;
        tick();
        total++;
        if (grant_out !== 16'h0001 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL enable_hold: got %h/%b, want 0001/1", grant_out, grant_valid);
        end
        grant_ready = 1'b1;
        tick();
        total++;
        if (grant_out !== 16'h0000 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_drain: got %h/%b, want 0000/0", grant_out, grant_valid);
        end
        tick();
        total++;
        if (grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_idle: got valid=%b, want 0", grant_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 16'h0001; enable = 1'b1; grant_ready = 1'b0;
        tick();
        grant_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (grant_out !== 16'h0000 || grant_valid !== 1'b0 || dut.ptr_q !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h/%b ptr=%0d, want 0000/0 ptr=0", grant_out,
                     grant_valid, dut.ptr_q);
        end
        req = 16'h0006; grant_ready = 1'b0;
        tick();
        total++;
        if (grant_out !== 16'h0002 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_grant: got %h/%b, want 0002/1", grant_out, grant_valid);
        end
    endtask

    task automatic test_random();
        int           waits [N];
        bit           acc;
        logic [N-1:0] g_obs;
        int           nbad_model;
        nbad_model = 0;
        do_reset();
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                req = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom);
            end
            enable      = ($urandom_range(0, 9) != 0);
            grant_ready = ($urandom_range(0, 2) != 0);
            acc   = grant_valid && grant_ready;
            g_obs = grant_out;
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] || (acc && g_obs[i])) waits[i] = 0;
                else if (acc) waits[i]++;
            end
            total++;
            if (grant_out !== m_grant() || grant_valid !== m_valid) begin
                bad++;
                if (nbad_model < 10)
                    $display("FAIL rand_model cyc %0d: got %h/%b, want %h/%b", c, grant_out,
                             grant_valid, m_grant(), m_valid);
                nbad_model++;
            end
            total++;
            if (grant_valid ? !$onehot(grant_out) : (grant_out != '0)) begin
                bad++;
                $display("FAIL rand_onehot cyc %0d: got %h/%b", c, grant_out, grant_valid);
            end
            if (acc) begin
                for (int i = 0; i < N; i++) begin
                    total++;
                    if (waits[i] > N - 1) begin
                        bad++;
                        $display("FAIL rand_fair cyc %0d req %0d: waited %0d, max %0d", c, i,
                                 waits[i], N - 1);
                        waits[i] = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hold();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
